tile_overlap_buffer: RTL and testbench

- Output-side stage directly downstream of the PosT-array reshuffle network, upstream of the output buffer.
- Accepts one reshuffled NxN output tile per handshake and overlap-adds its first OVERLAP rows onto the rows carried from the previous tile in the column.
- Streams completed rows out one per cycle.
- Drives the row-rotation `step` consumed by the reshuffle network, so tile alignment and overlap-add stay in lockstep.

---
 rtl/tile_overlap_buffer.sv | 139 +++++++++++++
 tb/tb_tile_overlap_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_overlap_buffer.sv
// Overlap-add stage after the reshuffle network: sums the first OVERLAP rows of each tile onto the carried rows, then streams rows.
// Latency: first row valid the cycle after a tile is accepted; one row per cycle while out_ready is high.
// Backpressure: out_row/out_last hold while out_ready is low; in_ready is high only in IDLE.
module tile_overlap_buffer #(
  parameter int N       = 4,
  parameter int WIDTH   = 32,
  parameter int OVERLAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*N*WIDTH-1:0]   in_patch,
  output logic [$clog2(N)-1:0]   step,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*WIDTH-1:0]     out_row,
  output logic                   out_last,
  output logic                   sat_flag
);

  localparam int CW = $clog2(N);
  // Carry store keeps at least one entry so the array is legal when OVERLAP is 0.
  localparam int CR = (OVERLAP > 0) ? OVERLAP : 1;
  localparam logic [CW-1:0] EMIT_END = CW'(N - OVERLAP - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);
  // (N - OVERLAP) mod N; truncation gives the modulo because N is a power of two.
  localparam logic [CW-1:0] STEP_INC = CW'(N - OVERLAP);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FLUSH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N*WIDTH-1:0] r_rows  [N];
  logic [N*WIDTH-1:0] r_carry [CR];
  logic [N*WIDTH-1:0] w_new   [N];
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_step;
  logic               r_last;
  logic               r_sat;
  logic               w_sat_any;
  logic               w_accept;
  logic               w_fire;

  assign step     = r_step;
  assign sat_flag = r_sat;
  // Rows of the column tail are emitted straight from the row store during FLUSH, so one mux serves both states.
  assign out_row  = r_rows[r_cnt];
  assign w_accept = in_valid & in_ready;
  assign w_fire   = out_valid & out_ready;

  // Overlap-add the leading rows of the incoming tile onto the carry with signed saturation.
  always_comb begin
    logic [WIDTH-1:0] v_a;
    logic [WIDTH-1:0] v_b;
    logic [WIDTH:0]   v_sum;
    v_a       = '0;
    v_b       = '0;
    v_sum     = '0;
    w_sat_any = 1'b0;
    for (int r = 0; r < N; r++) begin
      w_new[r] = in_patch[r*N*WIDTH +: N*WIDTH];
    end
    for (int r = 0; r < OVERLAP; r++) begin
      for (int c = 0; c < N; c++) begin
        v_a   = w_new[r][c*WIDTH +: WIDTH];
        v_b   = r_carry[r][c*WIDTH +: WIDTH];
        v_sum = {v_a[WIDTH-1], v_a} + {v_b[WIDTH-1], v_b};
        if (v_sum[WIDTH] != v_sum[WIDTH-1]) begin
          w_new[r][c*WIDTH +: WIDTH] = v_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}};
          w_sat_any = 1'b1;
        end else begin
          w_new[r][c*WIDTH +: WIDTH] = v_sum[WIDTH-1:0];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = (OVERLAP == 0) && r_last && (r_cnt == LAST_ROW);
        if (out_ready && (r_cnt == EMIT_END)) begin
          w_state_nxt = (r_last && (OVERLAP > 0)) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        out_valid = 1'b1;
        out_last  = r_last && (r_cnt == LAST_ROW);
        if (out_ready && (r_cnt == LAST_ROW)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row store, carry, row counter, step and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)  r_rows[r]  <= '0;
      for (int j = 0; j < CR; j++) r_carry[j] <= '0;
      r_cnt  <= '0;
      r_step <= '0;
      r_last <= 1'b0;
      r_sat  <= 1'b0;
    end else if (w_accept) begin
      for (int r = 0; r < N; r++)       r_rows[r]  <= w_new[r];
      for (int j = 0; j < OVERLAP; j++) r_carry[j] <= w_new[N-OVERLAP+j];
      r_last <= in_last;
      r_cnt  <= '0;
      r_step <= in_last ? '0 : r_step + STEP_INC;
      if (w_sat_any) r_sat <= 1'b1;
    end else if (w_fire) begin
      // Counter runs straight on from the EMIT rows into the FLUSH rows.
      r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_FLUSH) && (r_cnt == LAST_ROW)) begin
        for (int j = 0; j < CR; j++) r_carry[j] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_overlap_buffer.sv
// Directed bench for tile_overlap_buffer with N=4, WIDTH=32, OVERLAP=1.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Each scenario task carries its own expected rows.
module tb_tile_overlap_buffer;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OV = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [N*N*W-1:0]   in_patch;
  logic [1:0]         step;
  logic               out_valid;
  logic               out_ready;
  logic [N*W-1:0]     out_row;
  logic               out_last;
  logic               sat_flag;

  int total = 0;
  int bad   = 0;

  tile_overlap_buffer #(.N(N), .WIDTH(W), .OVERLAP(OV)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_patch(in_patch),
    .step(step),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] mk_row(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                             input logic [W-1:0] e2, input logic [W-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [N*N*W-1:0] mk_const(input logic [W-1:0] v);
    logic [N*N*W-1:0] t;
    for (int i = 0; i < N*N; i++) t[i*W +: W] = v;
    return t;
  endfunction

  function automatic logic [N*N*W-1:0] mk_ramp();
    logic [N*N*W-1:0] t;
    for (int i = 0; i < N*N; i++) t[i*W +: W] = W'(i);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a tile and returns one time unit after the accepting edge.
  task automatic send_tile(input logic [N*N*W-1:0] p, input logic last);
    in_patch = p;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && in_ready !== 1'b1; k++) tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_tile_ready: got in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_patch = '0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_patch = mk_const(32'd9); out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    total++;
    if (step !== 2'd0 || sat_flag !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got step=%0d sat=%b last=%b want 0 0 0", step, sat_flag, out_last);
    end
    total++;
    if (out_row !== '0) begin
      bad++;
      $display("FAIL reset_row: got %h want 0", out_row);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_no_accept: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_last();
    logic [N*W-1:0] exp;
    send_tile(mk_ramp(), 1'b1);
    for (int r = 0; r < N; r++) begin
      exp = mk_row(W'(4*r), W'(4*r+1), W'(4*r+2), W'(4*r+3));
      total++;
      if (out_valid !== 1'b1 || out_row !== exp) begin
        bad++;
        $display("FAIL single_row%0d: got v=%b %h want 1 %h", r, out_valid, out_row, exp);
      end
      total++;
      if (out_last !== (r == N-1)) begin
        bad++;
        $display("FAIL single_last%0d: got %b want %b", r, out_last, (r == N-1));
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || step !== 2'd0) begin
      bad++;
      $display("FAIL single_end: got v=%b rdy=%b step=%0d want 0 1 0", out_valid, in_ready, step);
    end
  endtask

  task automatic test_two_tiles();
    logic [W-1:0] expv [7];
    logic         expl [7];
    expv = '{32'd1, 32'd1, 32'd1, 32'd3, 32'd2, 32'd2, 32'd2};
    expl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    send_tile(mk_const(32'd1), 1'b0);
    total++;
    if (step !== 2'd3) begin
      bad++;
      $display("FAIL two_step_a: got %0d want 3", step);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL two_gap: got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        send_tile(mk_const(32'd2), 1'b1);
      end
      total++;
      if (out_valid !== 1'b1 || out_row !== mk_row(expv[i], expv[i], expv[i], expv[i]) || out_last !== expl[i]) begin
        bad++;
        $display("FAIL two_row%0d: got v=%b %h last=%b want %h last=%b", i, out_valid, out_row, out_last,
                 mk_row(expv[i], expv[i], expv[i], expv[i]), expl[i]);
      end
      tick();
    end
    total++;
    if (step !== 2'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL two_end: got step=%0d v=%b want 0 0", step, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] exp;
    send_tile(mk_ramp(), 1'b1);
    total++;
    if (out_row !== mk_row(32'd0, 32'd1, 32'd2, 32'd3)) begin
      bad++;
      $display("FAIL bp_row0: got %h", out_row);
    end
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_last !== 1'b0 ||
          out_row !== mk_row(32'd4, 32'd5, 32'd6, 32'd7)) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b last=%b %h", k, out_valid, in_ready, out_last, out_row);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int r = 1; r < N; r++) begin
      exp = mk_row(W'(4*r), W'(4*r+1), W'(4*r+2), W'(4*r+3));
      total++;
      if (out_valid !== 1'b1 || out_row !== exp || out_last !== (r == N-1)) begin
        bad++;
        $display("FAIL bp_row%0d: got v=%b %h last=%b want %h", r, out_valid, out_row, out_last, exp);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_end: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [N*N*W-1:0] ta;
    logic [N*N*W-1:0] tb;
    logic [N*W-1:0]   exp;
    ta = '0;
    ta[(3*N+0)*W +: W] = 32'h7FFF_FFF0;
    ta[(3*N+1)*W +: W] = 32'h8000_0010;
    tb = '0;
    tb[0*W +: W] = 32'h0000_0020;
    tb[1*W +: W] = 32'hFFFF_FF00;
    send_tile(ta, 1'b0);
    for (int r = 0; r < 3; r++) begin
      total++;
      if (out_row !== '0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL sat_a_row%0d: got v=%b %h want 0", r, out_valid, out_row);
      end
      tick();
    end
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL sat_flag_early: got %b want 0", sat_flag);
    end
    send_tile(tb, 1'b1);
    exp = mk_row(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0);
    total++;
    if (out_row !== exp) begin
      bad++;
      $display("FAIL sat_clamp: got %h want %h", out_row, exp);
    end
    total++;
    if (sat_flag !== 1'b1) begin
      bad++;
      $display("FAIL sat_flag_set: got %b want 1", sat_flag);
    end
    for (int r = 0; r < N; r++) tick();
    send_tile(mk_ramp(), 1'b1);
    total++;
    if (out_row !== mk_row(32'd0, 32'd1, 32'd2, 32'd3)) begin
      bad++;
      $display("FAIL sat_after_row0: got %h", out_row);
    end
    for (int r = 0; r < N; r++) tick();
    total++;
    if (sat_flag !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_sticky: got sat=%b v=%b want 1 0", sat_flag, out_valid);
    end
  endtask

  task automatic test_reset_mid_emit();
    send_tile(mk_const(32'd5), 1'b0);
    for (int r = 0; r < 2; r++) begin
      total++;
      if (out_row !== mk_row(32'd5, 32'd5, 32'd5, 32'd5)) begin
        bad++;
        $display("FAIL mid_row%0d: got %h want all 5", r, out_row);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || step !== 2'd0 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b rdy=%b step=%0d sat=%b want 0 1 0 0", out_valid, in_ready, step, sat_flag);
    end
    send_tile(mk_const(32'd1), 1'b1);
    for (int r = 0; r < N; r++) begin
      total++;
      if (out_valid !== 1'b1 || out_row !== mk_row(32'd1, 32'd1, 32'd1, 32'd1) || out_last !== (r == N-1)) begin
        bad++;
        $display("FAIL mid_b_row%0d: got v=%b %h last=%b want all 1", r, out_valid, out_row, out_last);
      end
      tick();
    end
    total++;
    if (step !== 2'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_end: got step=%0d v=%b want 0 0", step, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_last();
    test_two_tiles();
    test_backpressure();
    test_saturation();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
